// File: rtl/led_receiver_defs.sv
// Shared types and constants for the LED stream receiver.
package led_receiver_defs;

  localparam int LED_WORD_BITS = 24;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_SYNC = 2'd0;
  localparam rx_state_t RX_IDLE = 2'd1;
  localparam rx_state_t RX_HIGH = 2'd2;
  localparam rx_state_t RX_LOW  = 2'd3;

  typedef logic [1:0] rx_error_t;
  localparam rx_error_t ERR_OVERFLOW     = 2'd0;
  localparam rx_error_t ERR_SHORT_PULSE  = 2'd1;
  localparam rx_error_t ERR_STUCK_HIGH   = 2'd2;
  localparam rx_error_t ERR_PARTIAL_WORD = 2'd3;

endpackage

// File: rtl/led_stream_receiver_line_sync.sv
// Synchronizer, optional glitch filter (LED_RECEIVER_GLITCH_FILTER_EN) and edge detector.
module led_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic led_in,
  output logic line,
  output logic rise,
  output logic fall
);

  logic s1, s2, nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= led_in;
      s2 <= s1;
    end
  end

`ifdef LED_RECEIVER_GLITCH_FILTER_EN
  // Level only follows after three equal samples, so 1-2 cycle spikes vanish.
  logic s3, s4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s3 <= 1'b0;
      s4 <= 1'b0;
    end else begin
      s3 <= s2;
      s4 <= s3;
    end
  end

  assign nxt = ((s2 == s3) && (s3 == s4)) ? s2 : line;
`else
  assign nxt = s2;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      line <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      line <= nxt;
      rise <= nxt & ~line;
      fall <= ~nxt & line;
    end
  end

endmodule

// File: rtl/led_stream_receiver.sv
// Decodes the single-wire LED stream into 24-bit words, frame ends and protocol errors.
// Optional LED_RECEIVER_GLITCH_FILTER_EN enables the input glitch filter in led_line_sync.
module led_stream_receiver
  import led_receiver_defs::*;
#(
  parameter int BIT_THRESHOLD_CYCLES = 30,
  parameter int MIN_HIGH_CYCLES      = 8,
  parameter int MAX_HIGH_CYCLES      = 100,
  parameter int RESET_CYCLES         = 2500,
  parameter int MAX_LEDS             = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_in,
  output logic        word_valid,
  output logic [23:0] word_data,
  output logic [15:0] word_index,
  output logic        led_value,
  output logic        frame_done,
  output logic [15:0] frame_led_count,
  output logic        error,
  output logic [1:0]  error_code
);

  localparam logic [15:0] THR_C   = 16'(BIT_THRESHOLD_CYCLES);
  localparam logic [15:0] MINH_C  = 16'(MIN_HIGH_CYCLES);
  localparam logic [15:0] MAXH_C  = 16'(MAX_HIGH_CYCLES);
  localparam logic [15:0] RESET_C = 16'(RESET_CYCLES);
  localparam logic [15:0] LEDS_C  = 16'(MAX_LEDS);
  localparam logic [4:0]  LAST_BIT = 5'(LED_WORD_BITS - 1);

  logic line, rise, fall;

  led_line_sync u_line_sync (
    .clk    (clk),
    .rst    (rst),
    .led_in (led_in),
    .line   (line),
    .rise   (rise),
    .fall   (fall)
  );

  rx_state_t   state;
  logic [15:0] hi_cnt, lo_cnt, widx;
  logic [15:0] hi_inc, lo_inc;
  logic [4:0]  bit_cnt;
  logic [23:0] shreg, new_word;

  assign hi_inc   = (hi_cnt == 16'hFFFF) ? hi_cnt : hi_cnt + 16'd1;
  assign lo_inc   = (lo_cnt == 16'hFFFF) ? lo_cnt : lo_cnt + 16'd1;
  assign new_word = {shreg[22:0], (hi_cnt >= THR_C)};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= RX_SYNC;
      hi_cnt          <= '0;
      lo_cnt          <= '0;
      widx            <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      word_valid      <= 1'b0;
      word_data       <= '0;
      word_index      <= '0;
      led_value       <= 1'b0;
      frame_done      <= 1'b0;
      frame_led_count <= '0;
      error           <= 1'b0;
      error_code      <= '0;
    end else begin
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      case (state)
        RX_SYNC: begin
          if (line)                 lo_cnt <= '0;
          else if (lo_cnt >= RESET_C) state <= RX_IDLE;
          else                      lo_cnt <= lo_inc;
        end
        RX_IDLE: begin
          bit_cnt <= '0;
          widx    <= '0;
          if (rise) begin
            state  <= RX_HIGH;
            hi_cnt <= 16'd1;
          end
        end
        RX_HIGH: begin
          if (fall) begin
            if (hi_cnt < MINH_C) begin
              error      <= 1'b1;
              error_code <= ERR_SHORT_PULSE;
              lo_cnt     <= '0;
              state      <= RX_SYNC;
            end else begin
              shreg  <= new_word;
              lo_cnt <= 16'd1;
              state  <= RX_LOW;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                if (widx < LEDS_C) begin
                  word_valid <= 1'b1;
                  word_data  <= new_word;
                  word_index <= widx;
                  led_value  <= |new_word;
                  widx       <= widx + 16'd1;
                end else begin
                  error      <= 1'b1;
                  error_code <= ERR_OVERFLOW;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else begin
            hi_cnt <= hi_inc;
            if (hi_inc >= MAXH_C) begin
              error      <= 1'b1;
              error_code <= ERR_STUCK_HIGH;
              lo_cnt     <= '0;
              state      <= RX_SYNC;
            end
          end
        end
        default: begin // RX_LOW
          if (rise) begin
            state  <= RX_HIGH;
            hi_cnt <= 16'd1;
          end else if (lo_cnt >= RESET_C) begin
            frame_done      <= 1'b1;
            frame_led_count <= widx;
            state           <= RX_IDLE;
            if (bit_cnt != '0) begin
              error      <= 1'b1;
              error_code <= ERR_PARTIAL_WORD;
            end
          end else begin
            lo_cnt <= lo_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_stream_receiver.sv
// Directed bench for led_stream_receiver; MAX_LEDS is reduced to 3 so the overflow case stays short.
module tb_led_stream_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        led_in = 1'b0;
  logic        word_valid;
  logic [23:0] word_data;
  logic [15:0] word_index;
  logic        led_value;
  logic        frame_done;
  logic [15:0] frame_led_count;
  logic        error;
  logic [1:0]  error_code;

  led_stream_receiver #(.MAX_LEDS(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .led_in          (led_in),
    .word_valid      (word_valid),
    .word_data       (word_data),
    .word_index      (word_index),
    .led_value       (led_value),
    .frame_done      (frame_done),
    .frame_led_count (frame_led_count),
    .error           (error),
    .error_code      (error_code)
  );

  always #5 clk = ~clk;

`ifdef LED_RECEIVER_GLITCH_FILTER_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder; checks below compare its contents with hand-derived values.
  logic [23:0] wd [0:63];
  logic [15:0] wi [0:63];
  logic        lv [0:63];
  int wv_cnt = 0, wv_cyc = 0, fd_cnt = 0, err_cnt = 0, e_cyc = 0;
  logic [15:0] fcount = '0;
  logic [1:0]  ecode = '0;
  logic        e_fd = 1'b0;

  always @(negedge clk) begin
    if (word_valid) begin
      if (wv_cnt < 64) begin
        wd[wv_cnt] = word_data;
        wi[wv_cnt] = word_index;
        lv[wv_cnt] = led_value;
      end
      wv_cyc = cyc;
      wv_cnt = wv_cnt + 1;
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fcount = frame_led_count;
    end
    if (error) begin
      err_cnt = err_cnt + 1;
      ecode   = error_code;
      e_fd    = frame_done;
      e_cyc   = cyc;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int edge_cyc = 0;
  int b_wv, b_fd, b_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    led_in = 1'b1;
    repeat (b ? 40 : 20) @(negedge clk);
    led_in = 1'b0;
    edge_cyc = cyc;
    repeat (b ? 22 : 42) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic gap(input int n);
    led_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    b_wv = wv_cnt; b_fd = fd_cnt; b_err = err_cnt;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_word_valid", 32'(word_valid), 0);
    check("rst_word_data", 32'(word_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_frame_count", 32'(frame_led_count), 0);
    rst = 1'b1;
    gap(2600);

    // Single word
    mark();
    send_word(24'h010000);
    gap(2600);
    check("single_wv_cnt", 32'(wv_cnt - b_wv), 1);
    check("single_data", 32'(wd[b_wv]), 'h010000);
    check("single_index", 32'(wi[b_wv]), 0);
    check("single_led_value", 32'(lv[b_wv]), 1);
    check("single_latency", 32'(wv_cyc - edge_cyc), 32'(4 + EXTRA));
    check("single_fd_cnt", 32'(fd_cnt - b_fd), 1);
    check("single_fcount", 32'(fcount), 1);
    check("single_no_err", 32'(err_cnt - b_err), 0);

    // Full frame plus one overflowing word
    mark();
    send_word(24'h000000);
    send_word(24'h010000);
    send_word(24'h000000);
    send_word(24'h010000);
    check("full_ovf_err", 32'(err_cnt - b_err), 1);
    check("full_ovf_code", 32'(ecode), 0);
    gap(2600);
    check("full_wv_cnt", 32'(wv_cnt - b_wv), 3);
    for (int k = 0; k < 3; k++) begin
      check("full_index", 32'(wi[b_wv + k]), 32'(k));
      check("full_led_value", 32'(lv[b_wv + k]), 32'(k % 2));
    end
    check("full_data1", 32'(wd[b_wv + 1]), 'h010000);
    check("full_fcount", 32'(fcount), 3);
    check("full_fd_cnt", 32'(fd_cnt - b_fd), 1);

    // Partial word
    mark();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    gap(2600);
    check("partial_wv_cnt", 32'(wv_cnt - b_wv), 0);
    check("partial_fd_cnt", 32'(fd_cnt - b_fd), 1);
    check("partial_fcount", 32'(fcount), 0);
    check("partial_err_cnt", 32'(err_cnt - b_err), 1);
    check("partial_code", 32'(ecode), 3);
    check("partial_with_fd", 32'(e_fd), 1);

    // Stuck high, then a word that must be ignored
    mark();
    led_in = 1'b1;
    edge_cyc = cyc;
    repeat (200) @(negedge clk);
    gap(100);
    check("stuck_err_cnt", 32'(err_cnt - b_err), 1);
    check("stuck_code", 32'(ecode), 2);
    check("stuck_time", 32'(e_cyc - edge_cyc), 32'(103 + EXTRA));
    send_word(24'h0000FF);
    gap(2600);
    check("stuck_ignored", 32'(wv_cnt - b_wv), 0);
    check("stuck_no_fd", 32'(fd_cnt - b_fd), 0);
    send_word(24'hABCDEF);
    gap(2600);
    check("stuck_recover_data", 32'(wd[b_wv]), 'hABCDEF);
    check("stuck_recover_index", 32'(wi[b_wv]), 0);

    // Reset mid-word
    mark();
    for (int i = 0; i < 12; i++) send_bit(i[0]);
    rst = 1'b0;
    led_in = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_word_data", 32'(word_data), 0);
    check("midrst_word_index", 32'(word_index), 0);
    check("midrst_led_value", 32'(led_value), 0);
    check("midrst_frame_count", 32'(frame_led_count), 0);
    check("midrst_error_code", 32'(error_code), 0);
    rst = 1'b1;
    gap(2600);
    send_word(24'h000001);
    gap(2600);
    check("midrst_wv_cnt", 32'(wv_cnt - b_wv), 1);
    check("midrst_data", 32'(wd[b_wv]), 1);
    check("midrst_index", 32'(wi[b_wv]), 0);
    check("midrst_fd_cnt", 32'(fd_cnt - b_fd), 1);
    check("midrst_fcount", 32'(fcount), 1);

    // 1-cycle spike during a low phase
    mark();
    for (int i = 23; i >= 0; i--) begin
      send_bit(i[1]);
      if (i == 18) begin
        led_in = 1'b1;
        @(negedge clk);
        led_in = 1'b0;
        repeat (20) @(negedge clk);
      end
    end
    gap(2600);
`ifdef LED_RECEIVER_GLITCH_FILTER_EN
    check("spike_wv_cnt", 32'(wv_cnt - b_wv), 1);
    check("spike_data", 32'(wd[b_wv]), 'hCCCCCC);
    check("spike_err_cnt", 32'(err_cnt - b_err), 0);
    check("spike_fd_cnt", 32'(fd_cnt - b_fd), 1);
`else
    check("spike_wv_cnt", 32'(wv_cnt - b_wv), 0);
    check("spike_err_cnt", 32'(err_cnt - b_err), 1);
    check("spike_code", 32'(ecode), 1);
    check("spike_fd_cnt", 32'(fd_cnt - b_fd), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
